// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the FemtoRV32 core. One result bit
// per cycle: shift-add for multiply, restoring division for divide.
// Operands are converted to magnitudes on entry and the sign is fixed up on
// the way out.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   start        in   request a new operation (sampled only in IDLE)
//   funct3[2:0]  in   0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   rs1[31:0]    in   operand A (multiplicand / dividend)
//   rs2[31:0]    in   operand B (multiplier / divisor)
//   result[31:0] out  final result; holds its value between operations
//   result_valid out  one-cycle load strobe for the core's result register
//   busy         out  high while an operation is in flight
//
// Build option:
//   MULDIV_EARLY_OUT_EN  when defined, multiplies finish as soon as the
//                        remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return ~v + (2*XLEN)'(1);
  endfunction

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [2:0]        op_q,     op_d;
  // Multiply: 64-bit product accumulator. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q,    acc_d;
  // Multiply: shifting multiplicand. Divide: divisor in the low word.
  logic [2*XLEN-1:0] mcand_q,  mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              valid_q,  valid_d;
  logic              busy_q,   busy_d;

  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_sub_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

  // MULH/DIV/REM treat both operands as signed; MULHSU only rs1.
  assign a_sgn_s = (funct3 == 3'd1) || (funct3 == 3'd2) ||
                   (funct3 == 3'd4) || (funct3 == 3'd6);
  assign b_sgn_s = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign a_neg_s = a_sgn_s & rs1[XLEN-1];
  assign b_neg_s = b_sgn_s & rs2[XLEN-1];
  assign mag_a_s = a_neg_s ? neg_w(rs1) : rs1;
  assign mag_b_s = b_neg_s ? neg_w(rs2) : rs2;

  // Trial subtract on the shifted remainder (33 bits: old remainder plus the
  // quotient MSB shifted in).
  assign div_ge_s  = {1'b0, acc_q[2*XLEN-1:XLEN-1]} >= {2'b00, mcand_q[XLEN-1:0]};
  assign div_sub_s = acc_q[2*XLEN-2:XLEN-1] - mcand_q[XLEN-1:0];

  // Sign fix-up of the values that will be present after the final iteration.
  // A zero divisor clears neg_res_q on entry so the quotient stays all-ones.
  assign prod_fix_s = neg_res_q ? neg_dw(acc_d) : acc_d;
  assign quo_fix_s  = neg_res_q ? neg_w(acc_d[XLEN-1:0]) : acc_d[XLEN-1:0];
  assign rem_fix_s  = neg_rem_q ? neg_w(acc_d[2*XLEN-1:XLEN]) : acc_d[2*XLEN-1:XLEN];

  // FSM sequencing and one iteration of the multiply or divide datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = funct3;
          cnt_d     = '0;
          neg_rem_d = a_neg_s;
          state_d   = S_CALC;
          if (!funct3[2]) begin
            acc_d     = '0;
            mcand_d   = {{XLEN{1'b0}}, mag_a_s};
            mplier_d  = mag_b_s;
            neg_res_d = a_neg_s ^ b_neg_s;
          end else begin
            acc_d     = {{XLEN{1'b0}}, mag_a_s};
            mcand_d   = {{XLEN{1'b0}}, mag_b_s};
            mplier_d  = '0;
            neg_res_d = (a_neg_s ^ b_neg_s) & (rs2 != '0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_q[2]) begin
          acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          acc_d    = div_ge_s ? {div_sub_s, acc_q[XLEN-2:0], 1'b1}
                              : {acc_q[2*XLEN-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!op_q[2] && (mplier_d == '0)) begin
          state_d = S_DONE;
        end
`endif
        else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Result selection, loaded on the edge that enters DONE.
  always_comb begin
    result_d = result_q;
    valid_d  = 1'b0;
    busy_d   = (state_d != S_IDLE);
    if ((state_q == S_CALC) && (state_d == S_DONE)) begin
      valid_d = 1'b1;
      case (op_q)
        3'd0:                result_d = prod_fix_s[XLEN-1:0];
        3'd1, 3'd2, 3'd3:    result_d = prod_fix_s[2*XLEN-1:XLEN];
        3'd4, 3'd5:          result_d = quo_fix_s;
        3'd6, 3'd7:          result_d = rem_fix_s;
        default:             result_d = result_q;
      endcase
    end else begin
      valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 3'd0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule
